// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_DIV = 3'b011,
    OP_OR  = 3'b100,
    OP_MUL = 3'b101,
    OP_XOR = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  localparam int FLG_CARRY = 0;
  localparam int FLG_OVF   = 1;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_DZ    = 3;
  localparam int FLG_ERR   = 4;
  localparam int NFLAGS    = 5;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative datapath: shift-add multiply (LSB first) or restoring divide (MSB first), one step per cycle.
// done_o pulses combinationally on the WIDTH-th step, with lo_o/hi_o showing that step's result.
module alu_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             dz_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q, busy_d;
  logic             is_div_q, is_div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             last;

  // lo_q holds the multiplier (MUL) or the dividend turning into the quotient (DIV);
  // acc_q holds the partial product high half or the running remainder.
  always_comb begin
    mul_sum   = acc_q + (lo_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
    div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    last      = busy_q && (cnt_q == CW'(WIDTH - 1));

    busy_d   = busy_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    b_d      = b_q;

    if (start_i) begin
      busy_d   = 1'b1;
      is_div_d = is_div_i;
      cnt_d    = '0;
      acc_d    = '0;
      lo_d     = a_i;
      b_d      = b_i;
    end else if (busy_q) begin
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        busy_d = 1'b0;
      end
      if (is_div_q) begin
        // A zero divisor never goes negative, so the quotient fills with ones and A lands in the remainder.
        if (!div_trial[WIDTH]) begin
          acc_d = div_trial;
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift;
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = {1'b0, mul_sum[WIDTH:1]};
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
    end else begin
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
    end
  end

  assign done_o = last;
  assign lo_o   = lo_d;
  assign hi_o   = acc_d[WIDTH-1:0];
  assign dz_o   = is_div_q && (b_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: ADD/SUB/logic in one cycle, MUL/DIV over WIDTH cycles (WIDTH legal 4..16).
// Result and flags are held on the output channel until out_ready; nothing is accepted meanwhile.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_dz,
  output logic             out_err
);

  import alu_pkg::*;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [NFLAGS-1:0] flg_q, flg_d;

  op_e               op;
  logic              is_muldiv;
  logic              md_start;
  logic              md_done;
  logic              md_dz;
  logic [WIDTH-1:0]  md_lo;
  logic [WIDTH-1:0]  md_hi;

  logic [WIDTH:0]    sum_w;
  logic [WIDTH:0]    diff_w;
  logic [WIDTH-1:0]  sc_lo;
  logic [NFLAGS-1:0] sc_flg;

  assign op        = op_e'(in_op);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign in_ready  = (state_q == ST_IDLE);
  assign md_start  = in_ready && in_valid && is_muldiv;

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start),
    .is_div_i (op == OP_DIV),
    .a_i      (in_a),
    .b_i      (in_b),
    .done_o   (md_done),
    .lo_o     (md_lo),
    .hi_o     (md_hi),
    .dz_o     (md_dz)
  );

  always_comb begin
    sum_w  = {1'b0, in_a} + {1'b0, in_b};
    diff_w = {1'b0, in_a} - {1'b0, in_b};
    sc_lo  = '0;
    sc_flg = '0;
    case (op)
      OP_ADD: begin
        sc_lo             = sum_w[WIDTH-1:0];
        sc_flg[FLG_CARRY] = sum_w[WIDTH];
        sc_flg[FLG_OVF]   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the difference is the borrow, i.e. A < B.
        sc_lo             = diff_w[WIDTH-1:0];
        sc_flg[FLG_CARRY] = diff_w[WIDTH];
        sc_flg[FLG_OVF]   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  sc_lo = in_a & in_b;
      OP_OR:   sc_lo = in_a | in_b;
      OP_XOR:  sc_lo = in_a ^ in_b;
      OP_RSV:  sc_flg[FLG_ERR] = 1'b1;
      default: sc_lo = '0;
    endcase
    sc_flg[FLG_ZERO] = (sc_lo == '0);
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    flg_d   = flg_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_muldiv) begin
            state_d = ST_BUSY;
          end else begin
            lo_d    = sc_lo;
            hi_d    = '0;
            flg_d   = sc_flg;
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          lo_d            = md_lo;
          hi_d            = md_hi;
          flg_d           = '0;
          flg_d[FLG_ZERO] = ({md_hi, md_lo} == '0);
          flg_d[FLG_DZ]   = md_dz;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      flg_q   <= flg_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign out_lo    = lo_q;
  assign out_hi    = hi_q;
  assign out_carry = flg_q[FLG_CARRY];
  assign out_ovf   = flg_q[FLG_OVF];
  assign out_zero  = flg_q[FLG_ZERO];
  assign out_dz    = flg_q[FLG_DZ];
  assign out_err   = flg_q[FLG_ERR];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: driver queues hand-computed results, monitor pops on each output transfer.
module tb_alu_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [4:0]   fl;   // {carry, ovf, zero, dz, err}
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_lo;
  logic [W-1:0] out_hi;
  logic         out_carry;
  logic         out_ovf;
  logic         out_zero;
  logic         out_dz;
  logic         out_err;

  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;
  exp_t sb[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lo    (out_lo),
    .out_hi    (out_hi),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_dz    (out_dz),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endfunction

  function automatic exp_t mk(input logic [W-1:0] lo, input logic [W-1:0] hi,
                              input logic c, input logic v, input logic z,
                              input logic dz, input logic err);
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    e.fl = {c, v, z, dz, err};
    return e;
  endfunction

  // Monitor: pops one expectation per output transfer and checks values hold while stalled.
  exp_t held_val;
  bit   held = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || !out_valid) begin
      held = 1'b0;
    end else begin
      if (!out_ready) begin
        if (held)
          chk("hold_stable", 32'({out_lo, out_hi, out_carry, out_ovf, out_zero, out_dz, out_err}), 32'(held_val));
        held_val = {out_lo, out_hi, {out_carry, out_ovf, out_zero, out_dz, out_err}};
        held     = 1'b1;
      end else begin
        exp_t e;
        pops++;
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("out_lo", 32'(out_lo), 32'(e.lo));
          chk("out_hi", 32'(out_hi), 32'(e.hi));
          chk("out_flags", 32'({out_carry, out_ovf, out_zero, out_dz, out_err}), 32'(e.fl));
        end
      end
    end
  end

  task automatic accept(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_op    = 3'b000;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input exp_t e, input int exp_lat, input bit wait_out);
    int n;
    int rdy_seen;
    sb.push_back(e);
    accept(op, a, b);
    rdy_seen = 0;
    @(negedge clk);
    n = 1;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_seen++;
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("in_ready_while_busy", 32'(rdy_seen), 32'(0));
    if (wait_out) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int rdy_seen;
    int ov_seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'b000;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_outputs", 32'({out_lo, out_hi, out_carry, out_ovf, out_zero, out_dz, out_err}), 32'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));

    send(3'b000, 8'd200, 8'd100, mk(8'h2C, 8'h00, 1, 0, 0, 0, 0), 1, 1);  // ADD
    send(3'b001, 8'd5,   8'd7,   mk(8'hFE, 8'h00, 1, 0, 0, 0, 0), 1, 1);  // SUB borrow
    send(3'b001, 8'h80,  8'h01,  mk(8'h7F, 8'h00, 0, 1, 0, 0, 0), 1, 1);  // SUB overflow
    send(3'b000, 8'hFF,  8'h01,  mk(8'h00, 8'h00, 1, 0, 1, 0, 0), 1, 1);  // ADD wrap to zero
    send(3'b000, 8'h7F,  8'h01,  mk(8'h80, 8'h00, 0, 1, 0, 0, 0), 1, 1);  // ADD overflow
    send(3'b010, 8'hF0,  8'h0F,  mk(8'h00, 8'h00, 0, 0, 1, 0, 0), 1, 1);  // AND
    send(3'b100, 8'hA0,  8'h05,  mk(8'hA5, 8'h00, 0, 0, 0, 0, 0), 1, 1);  // OR
    send(3'b101, 8'd200, 8'd200, mk(8'h40, 8'h9C, 0, 0, 0, 0, 0), 9, 1);  // MUL
    send(3'b101, 8'd0,   8'd5,   mk(8'h00, 8'h00, 0, 0, 1, 0, 0), 9, 1);  // MUL zero
    send(3'b101, 8'hFF,  8'hFF,  mk(8'h01, 8'hFE, 0, 0, 0, 0, 0), 9, 1);  // MUL max
    send(3'b011, 8'd100, 8'd7,   mk(8'd14, 8'd2,  0, 0, 0, 0, 0), 9, 1);  // DIV
    send(3'b011, 8'd100, 8'd0,   mk(8'hFF, 8'd100,0, 0, 0, 1, 0), 9, 1);  // DIV by zero
    send(3'b011, 8'd7,   8'd100, mk(8'h00, 8'd7,  0, 0, 0, 0, 0), 9, 1);  // DIV small

    // Backpressure: hold the XOR result for 5 stalled cycles while offering new input.
    out_ready = 1'b0;
    send(3'b110, 8'hF0, 8'hFF, mk(8'h0F, 8'h00, 0, 0, 0, 0, 0), 1, 0);
    rdy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_op    = 3'b000;
      in_a     = 8'd1;
      in_b     = 8'd1;
      if (in_ready) rdy_seen++;
      @(negedge clk);
    end
    chk("bp_in_ready_low", 32'(rdy_seen), 32'(0));
    chk("bp_out_lo_held", 32'(out_lo), 32'(8'h0F));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    p0 = pops;
    @(negedge clk);
    @(negedge clk);
    chk("bp_single_transfer", 32'(pops - p0), 32'(1));
    chk("bp_out_valid_clear", 32'(out_valid), 32'(0));

    // Reset in the middle of a multiply after four iterations.
    accept(3'b101, 8'd200, 8'd200);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_outputs", 32'({out_lo, out_hi, out_carry, out_ovf, out_zero, out_dz, out_err}), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("midrst_no_result", 32'(ov_seen), 32'(0));
    chk("midrst_in_ready_after", 32'(in_ready), 32'(1));

    send(3'b000, 8'd1, 8'd1, mk(8'h02, 8'h00, 0, 0, 0, 0, 0), 1, 1);     // ADD after reset
    send(3'b111, 8'd5, 8'd3, mk(8'h00, 8'h00, 0, 0, 1, 0, 1), 1, 1);     // reserved op

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
